// File: rtl/risc16_seq_pkg.sv
// Shared types and constants for the RISC16 phase sequencer.
// Optional single-step support is selected with RISC16_SEQ_STEP_EN.
package risc16_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_HALT
   } state_t;

   localparam logic [4:0] TICK_T1   = 5'b10000;
   localparam logic [4:0] TICK_T2   = 5'b01000;
   localparam logic [4:0] TICK_T3   = 5'b00100;
   localparam logic [4:0] TICK_T4   = 5'b00010;
   localparam logic [4:0] TICK_T5   = 5'b00001;
   localparam logic [4:0] TICK_NONE = 5'b00000;

   localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;
   localparam logic [3:0] PHASE_HALT      = 4'hF;

endpackage

// File: rtl/risc16_step_gate.sv
// Single-step gate: one advance pulse per 0->1 transition of step_req.
// Only instantiated when RISC16_SEQ_STEP_EN is defined.
module risc16_step_gate (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic step_mode,
   input  logic step_req,
   output logic advance
);

   logic step_q;

   // History freezes with enable so a held request never re-triggers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= 1'b0;
      end else if (enable) begin
         step_q <= step_req;
      end
   end

   assign advance = !step_mode || (step_req && !step_q);

endmodule

// File: rtl/risc16_sequencer.sv
// RISC16 five-phase instruction sequencer (IDLE, T1..T5, HALT).
// Define RISC16_SEQ_STEP_EN to add step_mode/step_req single-stepping.
module risc16_sequencer
   import risc16_seq_pkg::*;
#(
   parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             instr_valid,
   input  logic [15:0]      instr_in,
   output logic             instr_ready,
   output logic [15:0]      instr_out,
   output logic [4:0]       tick,
   output logic [3:0]       phase_num,
   output logic             busy,
   output logic             halted,
   input  logic             halt_clr,
`ifdef RISC16_SEQ_STEP_EN
   input  logic             step_mode,
   input  logic             step_req,
`endif
   output logic [CNT_W-1:0] instr_count
);

   state_t state;
   logic   advance;
   logic   accept;

`ifdef RISC16_SEQ_STEP_EN
   risc16_step_gate u_step_gate (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .step_mode (step_mode),
      .step_req  (step_req),
      .advance   (advance)
   );
`else
   assign advance = 1'b1;
`endif

   // rst_n gates ready so it stays low for the whole reset window.
   assign instr_ready = (state == S_IDLE) && enable && rst_n;
   assign accept      = instr_valid && instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         instr_out   <= 16'h0000;
         instr_count <= '0;
      end else if (enable) begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  instr_out <= instr_in;
                  state     <= S_T1;
               end
            end
            S_T1: if (advance) state <= S_T2;
            S_T2: if (advance) state <= S_T3;
            S_T3: if (advance) state <= S_T4;
            S_T4: if (advance) state <= S_T5;
            S_T5: begin
               if (advance) begin
                  instr_count <= instr_count + CNT_W'(1);
                  if (instr_out[15:12] == HALT_OPCODE)
                     state <= S_HALT;
                  else
                     state <= S_IDLE;
               end
            end
            S_HALT: if (halt_clr) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      tick      = TICK_NONE;
      phase_num = 4'd0;
      busy      = 1'b0;
      halted    = 1'b0;
      unique case (state)
         S_IDLE: ;
         S_T1: begin
            tick      = TICK_T1;
            phase_num = 4'd1;
            busy      = 1'b1;
         end
         S_T2: begin
            tick      = TICK_T2;
            phase_num = 4'd2;
            busy      = 1'b1;
         end
         S_T3: begin
            tick      = TICK_T3;
            phase_num = 4'd3;
            busy      = 1'b1;
         end
         S_T4: begin
            tick      = TICK_T4;
            phase_num = 4'd4;
            busy      = 1'b1;
         end
         S_T5: begin
            tick      = TICK_T5;
            phase_num = 4'd5;
            busy      = 1'b1;
         end
         S_HALT: begin
            phase_num = PHASE_HALT;
            halted    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_risc16_sequencer.sv
// Scoreboard bench for risc16_sequencer (CNT_W=4 to reach counter wrap).
// Step-mode vectors run only when RISC16_SEQ_STEP_EN is defined.
module tb_risc16_sequencer;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        instr_valid;
   logic [15:0] instr_in;
   logic        instr_ready;
   logic [15:0] instr_out;
   logic [4:0]  tick;
   logic [3:0]  phase_num;
   logic        busy;
   logic        halted;
   logic        halt_clr;
   logic [3:0]  instr_count;
`ifdef RISC16_SEQ_STEP_EN
   logic        step_mode;
   logic        step_req;
`endif

   int n_chk;
   int n_fail;

   typedef struct {
      logic [4:0]  tick;
      logic [3:0]  ph;
      logic        busy;
      logic        halted;
      logic        rdy;
      logic [3:0]  cnt;
      logic [15:0] out;
   } exp_t;

   exp_t sb[$];
   exp_t m;

   risc16_sequencer #(
      .CNT_W (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .instr_valid (instr_valid),
      .instr_in    (instr_in),
      .instr_ready (instr_ready),
      .instr_out   (instr_out),
      .tick        (tick),
      .phase_num   (phase_num),
      .busy        (busy),
      .halted      (halted),
      .halt_clr    (halt_clr),
`ifdef RISC16_SEQ_STEP_EN
      .step_mode   (step_mode),
      .step_req    (step_req),
`endif
      .instr_count (instr_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare the oldest expectation at each falling edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         m = sb.pop_front();
         chk("tick",        16'(tick),        16'(m.tick));
         chk("phase_num",   16'(phase_num),   16'(m.ph));
         chk("busy",        16'(busy),        16'(m.busy));
         chk("halted",      16'(halted),      16'(m.halted));
         chk("instr_ready", 16'(instr_ready), 16'(m.rdy));
         chk("instr_count", 16'(instr_count), 16'(m.cnt));
         chk("instr_out",   instr_out,        m.out);
      end
   end

   task automatic push(input logic [3:0] ph, input logic [3:0] cnt,
                       input logic [15:0] out);
      exp_t e;
      e.ph     = ph;
      e.cnt    = cnt;
      e.out    = out;
      e.busy   = (ph >= 4'd1) && (ph <= 4'd5);
      e.halted = (ph == 4'hF);
      e.rdy    = (ph == 4'd0) && enable && rst_n;
      case (ph)
         4'd1:    e.tick = 5'b10000;
         4'd2:    e.tick = 5'b01000;
         4'd3:    e.tick = 5'b00100;
         4'd4:    e.tick = 5'b00010;
         4'd5:    e.tick = 5'b00001;
         default: e.tick = 5'b00000;
      endcase
      sb.push_back(e);
   endtask

   task automatic cyc(input logic e, input logic v, input logic [15:0] d,
                      input logic h, input logic [3:0] ph,
                      input logic [3:0] cnt, input logic [15:0] out);
      enable      = e;
      instr_valid = v;
      instr_in    = d;
      halt_clr    = h;
      @(posedge clk);
      #1;
      push(ph, cnt, out);
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] d;
      n_chk       = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      enable      = 1'b1;
      instr_valid = 1'b1;
      instr_in    = 16'hABCD;
      halt_clr    = 1'b0;
`ifdef RISC16_SEQ_STEP_EN
      step_mode   = 1'b0;
      step_req    = 1'b0;
`endif
      #2;
      push(4'd0, 4'd0, 16'h0000);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 16'h0000);

      // Basic instruction, count 0 -> 1
      cyc(1'b1, 1'b1, 16'h1234, 1'b0, 4'd1, 4'd0, 16'h1234);
      for (int p = 2; p <= 5; p++)
         cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'(p), 4'd0, 16'h1234);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd1, 16'h1234);

      // Halt opcode, then clear
      cyc(1'b1, 1'b1, 16'hF000, 1'b0, 4'd1, 4'd1, 16'hF000);
      for (int p = 2; p <= 5; p++)
         cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'(p), 4'd1, 16'hF000);
      cyc(1'b1, 1'b1, 16'h4444, 1'b0, 4'hF, 4'd2, 16'hF000);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'hF, 4'd2, 16'hF000);
      cyc(1'b0, 1'b0, 16'h0000, 1'b1, 4'hF, 4'd2, 16'hF000);
      cyc(1'b1, 1'b1, 16'h5555, 1'b1, 4'd0, 4'd2, 16'hF000);

      // Freeze in T3 for three disabled cycles; halt_clr ignored in T4
      cyc(1'b1, 1'b1, 16'h2222, 1'b0, 4'd1, 4'd2, 16'h2222);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd2, 4'd2, 16'h2222);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd3, 4'd2, 16'h2222);
      for (int k = 0; k < 3; k++)
         cyc(1'b0, 1'b1, 16'h9999, 1'b1, 4'd3, 4'd2, 16'h2222);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd4, 4'd2, 16'h2222);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1, 4'd5, 4'd2, 16'h2222);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd3, 16'h2222);

      // Reset during T4 aborts without retiring
      cyc(1'b1, 1'b1, 16'h3333, 1'b0, 4'd1, 4'd3, 16'h3333);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd2, 4'd3, 16'h3333);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd3, 4'd3, 16'h3333);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd4, 4'd3, 16'h3333);
      rst_n = 1'b0;
      #1;
      push(4'd0, 4'd0, 16'h0000);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 16'h0000);

      // 16 back-to-back instructions: 6 cycles each, counter wraps
      for (int i = 0; i < 16; i++) begin
         d = 16'h0100 + 16'(i);
         cyc(1'b1, 1'b1, d, 1'b0, 4'd1, 4'(i), d);
         for (int p = 2; p <= 5; p++)
            cyc(1'b1, 1'b1, ~d, 1'b0, 4'(p), 4'(i), d);
         cyc(1'b1, 1'b1, ~d, 1'b0, 4'd0, 4'(i + 1), d);
      end

`ifdef RISC16_SEQ_STEP_EN
      // Held step_req advances exactly one phase
      step_mode = 1'b1;
      step_req  = 1'b0;
      cyc(1'b1, 1'b1, 16'h0777, 1'b0, 4'd1, 4'd0, 16'h0777);
      step_req = 1'b1;
      for (int k = 0; k < 10; k++)
         cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd2, 4'd0, 16'h0777);
      step_req = 1'b0;
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd2, 4'd0, 16'h0777);
      step_req = 1'b1;
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd3, 4'd0, 16'h0777);
      step_req  = 1'b0;
      step_mode = 1'b0;
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd4, 4'd0, 16'h0777);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd5, 4'd0, 16'h0777);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd1, 16'h0777);
`endif

      for (int k = 0; k < 4 && sb.size() > 0; k++)
         @(negedge clk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
